uart_rx: RTL and testbench

- 8N1 UART receiver. Counterpart of the team's UART transmitter; same bit timing parameter and same frame format (start 0, 8 data bits LSB first, stop 1).
- Takes an asynchronous serial line and delivers each received byte with a one-cycle valid strobe.
- Flags framing errors and rejects glitches on the start bit.
- Used for loopback and debug/config links alongside the MIPI receiver logic.

---
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with start-glitch rejection and framing-error strobe
`timescale 1ns/1ps

module uart_rx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam logic [7:0] MID  = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t      state_q;
  logic        sync1_q;
  logic        rx_q;
  logic [7:0]  count_q;
  logic [7:0]  count_d;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        dv_q;
  logic        ferr_q;
  logic        active_q;
  logic [7:0]  byte_q;

  assign count_d = count_q + 8'd1;

  // Synchronizer resets to idle-high so reset release never looks like a start edge.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      sync1_q <= i_Rx_Serial;
      rx_q    <= sync1_q;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= IDLE;
      count_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      active_q  <= 1'b0;
      byte_q    <= 8'd0;
    end else begin
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          count_q   <= 8'd0;
          bit_idx_q <= 3'd0;
          if (!rx_q) begin
            state_q  <= START;
            active_q <= 1'b1;
          end
        end
        START: begin
          if (count_q < MID) begin
            count_q <= count_d;
          end else if (!rx_q) begin
            count_q <= 8'd0;
            state_q <= DATA;
          end else begin
            state_q  <= IDLE;
            active_q <= 1'b0;
          end
        end
        DATA: begin
          if (count_q < LAST) begin
            count_q <= count_d;
          end else begin
            count_q            <= 8'd0;
            shift_q[bit_idx_q] <= rx_q;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= 3'd0;
              state_q   <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (count_q < LAST) begin
            count_q <= count_d;
          end else begin
            count_q  <= 8'd0;
            active_q <= 1'b0;
            if (rx_q) begin
              byte_q  <= shift_q;
              dv_q    <= 1'b1;
              state_q <= CLEANUP;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end
        end
        CLEANUP: begin
          state_q <= IDLE;
        end
        // A held-low line (break) is reported once; wait here until it releases.
        WAIT_IDLE: begin
          if (rx_q) state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          count_q   <= 8'd0;
          bit_idx_q <= 3'd0;
          active_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = ferr_q;
  assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at CLKS_PER_BIT=8
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int      CPB    = 8;
  localparam realtime CLK_NS = 10.0;
  localparam realtime BIT_NS = 80.0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       dv;
  logic [7:0] rx_byte;
  logic       ferr;
  logic       active;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Rst_n        (rst_n),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (dv),
    .o_Rx_Byte      (rx_byte),
    .o_Rx_Frame_Err (ferr),
    .o_Rx_Active    (active)
  );

  always #(CLK_NS / 2) clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         chk_lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   dv_cnt = 0;
  int   fe_cnt = 0;
  bit   active_seen = 0;
  bit   prev_dv = 0;
  bit   prev_fe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // Acts as the transmitter model: bit period may be fractional to exercise clock tolerance.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input realtime bit_ns,
                            input bit exp_ok, input bit chk_lat);
    exp_t e;
    if (exp_ok) begin
      e.data = data;
      e.start = cyc;
      e.chk_lat = chk_lat;
      sb.push_back(e);
    end
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic align();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (dv && ferr) check("strobe_excl", 1, 0);
    if (dv && prev_dv) check("dv_width", 1, 0);
    if (ferr && prev_fe) check("ferr_width", 1, 0);
    prev_dv = dv;
    prev_fe = ferr;
    if (active) active_seen = 1;
    if (ferr) fe_cnt++;
    if (dv) begin
      dv_cnt++;
      if (sb.size() == 0) begin
        check("dv_unexpected", {24'd0, rx_byte}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("rx_byte", {24'd0, rx_byte}, {24'd0, e.data});
        if (e.chk_lat) begin
          lat = cyc - e.start;
          check("latency_79pm1", (lat >= 78 && lat <= 80) ? 32'd1 : 32'd0, 32'd1);
        end
      end
    end
  end

  initial begin
    int dv_before;
    int waited;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_dv", dv, 0);
    check("rst_ferr", ferr, 0);
    check("rst_active", active, 0);
    check("rst_byte", rx_byte, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // single byte, active observed mid-frame
    align();
    fork
      send_frame(8'hA5, 1'b1, BIT_NS, 1, 1);
      begin
        #(BIT_NS * 4);
        check("active_mid", active, 1);
      end
    join
    repeat (20) @(posedge clk);
    #2;
    check("single_dv_cnt", dv_cnt, 1);
    check("single_fe_cnt", fe_cnt, 0);
    check("idle_active", active, 0);

    // back-to-back with no gap
    align();
    send_frame(8'h00, 1'b1, BIT_NS, 1, 1);
    send_frame(8'hFF, 1'b1, BIT_NS, 1, 1);
    send_frame(8'h3C, 1'b1, BIT_NS, 1, 1);
    repeat (20) @(posedge clk);
    #2;
    check("b2b_dv_cnt", dv_cnt, 4);

    // loopback of 256 random bytes
    align();
    for (int i = 0; i < 256; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, BIT_NS, 1, 1);
    repeat (20) @(posedge clk);
    #2;
    check("loop_dv_cnt", dv_cnt, 260);

    // start glitch
    align();
    active_seen = 0;
    dv_before = dv_cnt;
    rx = 1'b0;
    #(CLK_NS * 2);
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    check("glitch_active_seen", active_seen, 1);
    check("glitch_active_low", active, 0);
    check("glitch_no_dv", dv_cnt, dv_before);
    check("glitch_no_fe", fe_cnt, 0);
    align();
    send_frame(8'h55, 1'b1, BIT_NS, 1, 1);
    repeat (20) @(posedge clk);

    // framing error followed by a long break
    align();
    dv_before = dv_cnt;
    send_frame(8'h81, 1'b0, BIT_NS, 0, 0);
    #(BIT_NS * 40);
    check("break_fe_once", fe_cnt, 1);
    check("break_byte_held", rx_byte, 8'h55);
    check("break_no_dv", dv_cnt, dv_before);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    align();
    send_frame(8'h42, 1'b1, BIT_NS, 1, 1);
    repeat (20) @(posedge clk);

    // asynchronous reset during data bit 4
    align();
    dv_before = dv_cnt;
    fork
      send_frame(8'hF0, 1'b1, BIT_NS, 0, 0);
      begin
        #444;
        rst_n = 1'b0;
        #1;
        check("mid_rst_dv", dv, 0);
        check("mid_rst_ferr", ferr, 0);
        check("mid_rst_active", active, 0);
        check("mid_rst_byte", rx_byte, 0);
        #50;
        rst_n = 1'b1;
      end
    join
    repeat (30) @(posedge clk);
    #2;
    check("remnant_no_dv", dv_cnt, dv_before);
    check("remnant_no_fe", fe_cnt, 1);
    align();
    send_frame(8'h99, 1'b1, BIT_NS, 1, 1);
    repeat (20) @(posedge clk);

    // +/-3% bit-rate tolerance
    align();
    send_frame(8'h6B, 1'b1, BIT_NS * 1.03125, 1, 0);
    repeat (20) @(posedge clk);
    align();
    send_frame(8'h6B, 1'b1, BIT_NS * 0.96875, 1, 0);

    waited = 0;
    while (sb.size() != 0 && waited < 300) begin
      @(posedge clk);
      waited++;
    end
    #2;
    check("sb_drain", sb.size(), 0);
    check("total_dv_cnt", dv_cnt, 265);
    check("total_fe_cnt", fe_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
